// File: rtl/turn_input_conditioner.sv
// ============================================================================
// turn_input_conditioner: sync + debounce two active-low buttons and deliver
// one turn command per press on the game tick. Option macro: TURN_QUEUE_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module turn_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btL,
    input  logic btR,
    input  logic tick,
    output logic turnleft,
    output logic turnright,
    output logic pend_left,
    output logic pend_right
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] raw;
    logic [1:0] press;   // bit 0 = left, bit 1 = right

    assign raw = {btR, btL};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_button
            logic             sync_a;
            logic             sync_b;
            logic             db;
            logic             db_prev;
            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_a  <= 1'b1;
                    sync_b  <= 1'b1;
                    db      <= 1'b1;
                    db_prev <= 1'b1;
                    cnt     <= '0;
                end else begin
                    sync_a  <= raw[gi];
                    sync_b  <= sync_a;
                    db_prev <= db;
                    if (sync_b != db) begin
                        if (cnt == CNT_MAX) begin
                            db  <= sync_b;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
            end

            // Only the debounced falling edge (press) is an event
            assign press[gi] = db_prev & ~db;
        end
    endgenerate

`ifdef TURN_QUEUE_EN
    // Two-entry FIFO of turn codes; an entry bit of 1 means left
    logic [1:0] count, count_d;
    logic       head, head_d;
    logic       tail, tail_d;
    logic [1:0] count_mid;
    logic       single_press;

    assign single_press = press[0] ^ press[1];

    always_comb begin
        count_mid = count;
        head_d    = head;
        tail_d    = tail;
        if (tick && (count != 2'd0)) begin
            head_d    = tail;
            count_mid = count - 2'd1;
        end
        count_d = count_mid;
        if (single_press) begin
            if (count_mid == 2'd0) begin
                head_d  = press[0];
                count_d = 2'd1;
            end else if (count_mid == 2'd1) begin
                tail_d  = press[0];
                count_d = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= 2'd0;
            head      <= 1'b0;
            tail      <= 1'b0;
            turnleft  <= 1'b0;
            turnright <= 1'b0;
        end else begin
            count <= count_d;
            head  <= head_d;
            tail  <= tail_d;
            if (tick) begin
                turnleft  <= (count != 2'd0) &  head;
                turnright <= (count != 2'd0) & ~head;
            end
        end
    end

    assign pend_left  = (count != 2'd0) &  head;
    assign pend_right = (count != 2'd0) & ~head;
`else
    logic pl_d;
    logic pr_d;

    // Tick consumes first, then a same-cycle press refills the slot
    always_comb begin
        pl_d = pend_left;
        pr_d = pend_right;
        if (tick) begin
            pl_d = 1'b0;
            pr_d = 1'b0;
        end
        if (press == 2'b11) begin
            pl_d = 1'b0;
            pr_d = 1'b0;
        end else if (press[0]) begin
            pl_d = 1'b1;
            pr_d = 1'b0;
        end else if (press[1]) begin
            pl_d = 1'b0;
            pr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_left  <= 1'b0;
            pend_right <= 1'b0;
            turnleft   <= 1'b0;
            turnright  <= 1'b0;
        end else begin
            pend_left  <= pl_d;
            pend_right <= pr_d;
            if (tick) begin
                turnleft  <= pend_left;
                turnright <= pend_right;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_turn_input_conditioner.sv
// Directed self-checking bench for turn_input_conditioner (DEBOUNCE_CYCLES=4).
`default_nettype none

module tb_turn_input_conditioner;

`ifdef TURN_QUEUE_EN
    localparam bit Q = 1'b1;
`else
    localparam bit Q = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btL = 1'b1;
    logic btR = 1'b1;
    logic tick = 1'b0;
    logic turnleft, turnright, pend_left, pend_right;

    int checks = 0;
    int errors = 0;

    turn_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .btL(btL), .btR(btR), .tick(tick),
        .turnleft(turnleft), .turnright(turnright),
        .pend_left(pend_left), .pend_right(pend_right)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic press(input bit l, input bit r);
        btL = ~l;
        btR = ~r;
        step(8);
        btL = 1'b1;
        btR = 1'b1;
        step(8);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btL = 1'b0;
        step(3);
        checks++; if (turnleft !== 1'b0) begin errors++; $display("FAIL rst_turnleft got %b exp 0", turnleft); end
        checks++; if (pend_left !== 1'b0) begin errors++; $display("FAIL rst_pend_left got %b exp 0", pend_left); end
        checks++; if ({turnright, pend_right} !== 2'b00) begin errors++; $display("FAIL rst_right got %b exp 00", {turnright, pend_right}); end
        reset = 1'b0;
        step(6);
        checks++; if (pend_left !== 1'b0) begin errors++; $display("FAIL lat_early got %b exp 0", pend_left); end
        step(1);
        checks++; if (pend_left !== 1'b1) begin errors++; $display("FAIL lat_clk7 got %b exp 1", pend_left); end
        do_tick();
        checks++; if ({turnleft, pend_left} !== 2'b10) begin errors++; $display("FAIL tick1 got %b exp 10", {turnleft, pend_left}); end
        do_tick();
        checks++; if (turnleft !== 1'b0) begin errors++; $display("FAIL tick2 got %b exp 0", turnleft); end
        btL = 1'b1;
        step(10);
        checks++; if (pend_left !== 1'b0) begin errors++; $display("FAIL release_event got %b exp 0", pend_left); end
    endtask

    task automatic test_debounce();
        int  rises = 0;
        logic prev = pend_left;
        for (int i = 0; i < 10; i++) begin
            btL = (i % 2 == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 2; k++) begin
                step(1);
                if (pend_left && !prev) rises++;
                prev = pend_left;
            end
        end
        checks++; if (rises !== 0) begin errors++; $display("FAIL bounce_phase got %0d exp 0", rises); end
        btL = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            if (pend_left && !prev) rises++;
            prev = pend_left;
        end
        checks++; if (rises !== 1) begin errors++; $display("FAIL bounce_rises got %0d exp 1", rises); end
        btL = 1'b1;
        step(10);
        do_tick();
        checks++; if (turnleft !== 1'b1) begin errors++; $display("FAIL bounce_turn got %b exp 1", turnleft); end
        btL = 1'b0;
        step(3);
        btL = 1'b1;
        step(12);
        checks++; if (pend_left !== 1'b0) begin errors++; $display("FAIL short_pulse got %b exp 0", pend_left); end
    endtask

    task automatic test_last_wins();
        press(1'b1, 1'b0);
        checks++; if (pend_left !== 1'b1) begin errors++; $display("FAIL lw_pendL got %b exp 1", pend_left); end
        press(1'b0, 1'b1);
        checks++; if ({pend_left, pend_right} !== {Q, ~Q}) begin errors++; $display("FAIL lw_pend got %b exp %b", {pend_left, pend_right}, {Q, ~Q}); end
        do_tick();
        checks++; if ({turnleft, turnright} !== {Q, ~Q}) begin errors++; $display("FAIL lw_tick1 got %b exp %b", {turnleft, turnright}, {Q, ~Q}); end
        do_tick();
        checks++; if ({turnleft, turnright} !== {1'b0, Q}) begin errors++; $display("FAIL lw_tick2 got %b exp %b", {turnleft, turnright}, {1'b0, Q}); end
    endtask

    task automatic test_both();
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        checks++; if ({pend_left, pend_right} !== {Q, 1'b0}) begin errors++; $display("FAIL both_pend got %b exp %b", {pend_left, pend_right}, {Q, 1'b0}); end
        do_tick();
        checks++; if ({turnleft, turnright} !== {Q, 1'b0}) begin errors++; $display("FAIL both_tick got %b exp %b", {turnleft, turnright}, {Q, 1'b0}); end
    endtask

    task automatic test_press_on_tick();
        press(1'b1, 1'b0);
        btL = 1'b0;
        step(6);
        do_tick();
        checks++; if ({turnleft, pend_left} !== 2'b11) begin errors++; $display("FAIL pot_tick got %b exp 11", {turnleft, pend_left}); end
        btL = 1'b1;
        step(8);
        do_tick();
        checks++; if ({turnleft, pend_left} !== 2'b10) begin errors++; $display("FAIL pot_next got %b exp 10", {turnleft, pend_left}); end
        do_tick();
        checks++; if (turnleft !== 1'b0) begin errors++; $display("FAIL pot_drain got %b exp 0", turnleft); end
    endtask

    task automatic test_queue();
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        checks++; if ({pend_left, pend_right, turnleft} !== 3'b100) begin errors++; $display("FAIL q_pend got %b exp 100", {pend_left, pend_right, turnleft}); end
        do_tick();
        checks++; if ({turnleft, turnright} !== 2'b10) begin errors++; $display("FAIL q_tick1 got %b exp 10", {turnleft, turnright}); end
        do_tick();
        checks++; if ({turnleft, turnright} !== {1'b0, Q}) begin errors++; $display("FAIL q_tick2 got %b exp %b", {turnleft, turnright}, {1'b0, Q}); end
        do_tick();
        checks++; if ({turnleft, turnright} !== 2'b00) begin errors++; $display("FAIL q_tick3 got %b exp 00", {turnleft, turnright}); end
    endtask

    task automatic test_reset_midway();
        press(1'b1, 1'b0);
        do_tick();
        press(1'b1, 1'b0);
        btL = 1'b0;
        step(4);
        reset = 1'b1;
        #1;
        checks++; if ({turnleft, pend_left} !== 2'b00) begin errors++; $display("FAIL mid_reset got %b exp 00", {turnleft, pend_left}); end
        btL = 1'b1;
        step(3);
        reset = 1'b0;
        step(12);
        checks++; if ({pend_left, pend_right} !== 2'b00) begin errors++; $display("FAIL mid_discard got %b exp 00", {pend_left, pend_right}); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_last_wins();
        test_both();
        test_press_on_tick();
        test_queue();
        test_reset_midway();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
